// File: rtl/control_types.sv
// Shared control-path types: memory access opcodes plus the MMIO register
// map and STATUS bit layout used by the data-side memory block.
package control_types;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_op_t;

    localparam logic [31:0] TXDATA_OFF = 32'd0;
    localparam logic [31:0] STATUS_OFF = 32'd4;
    localparam logic [31:0] CYCLE_OFF  = 32'd8;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 8;

    function automatic logic is_store_op(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. A push while full and a pop while empty are
// both dropped; fullness is judged before any same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o      = (count_q == (PW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/data_memory_mmio.sv
// MEM-stage data memory: byte-addressable RAM with combinational loads,
// plus an MMIO block holding a TX byte FIFO, its status and a cycle counter.
module data_memory_mmio
    import control_types::*;
#(
    parameter int          MEM_SIZE_BYTES = 1024,
    parameter int          TX_FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_wr_en,
    input  mem_op_t     mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        misaligned,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int          WORDS       = MEM_SIZE_BYTES / 4;
    localparam int          WAW         = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int          CW          = $clog2(TX_FIFO_DEPTH) + 1;
    localparam logic [31:0] TX_ADDR     = MMIO_BASE + TXDATA_OFF;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + STATUS_OFF;
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + CYCLE_OFF;

    logic [31:0]    ram_q [WORDS];
    logic [31:0]    cycle_q, cycle_d;
    logic           overflow_q, overflow_d;

    logic [WAW-1:0] word_idx;
    logic           in_ram, hit_tx, hit_status, hit_cycle;
    logic           is_byte, is_half, is_word;
    logic           store_ok;
    logic [3:0]     byte_en;
    logic [31:0]    wdata;
    logic [31:0]    rd_word, lane;
    logic [31:0]    status_word;

    logic           fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;

    // MMIO registers decode on the word address so LB/LH can pick any lane.
    assign in_ram     = (mem_addr < 32'(MEM_SIZE_BYTES));
    assign hit_tx     = (mem_addr[31:2] == TX_ADDR[31:2]);
    assign hit_status = (mem_addr[31:2] == STATUS_ADDR[31:2]);
    assign hit_cycle  = (mem_addr[31:2] == CYCLE_ADDR[31:2]);
    assign word_idx   = mem_addr[WAW+1:2];

    assign is_byte    = (mem_op == MEM_LB) || (mem_op == MEM_LBU) || (mem_op == MEM_SB);
    assign is_half    = (mem_op == MEM_LH) || (mem_op == MEM_LHU) || (mem_op == MEM_SH);
    assign is_word    = (mem_op == MEM_LW) || (mem_op == MEM_SW);
    assign misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
    assign store_ok   = mem_wr_en && is_store_op(mem_op) && !misaligned;

    always_comb begin
        status_word = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_OVF_BIT]   = overflow_q;
        status_word[STATUS_COUNT_LSB +: 8] = 8'(fifo_count);
    end

    always_comb begin
        rd_word = '0;
        if (in_ram)          rd_word = ram_q[word_idx];
        else if (hit_status) rd_word = status_word;
        else if (hit_cycle)  rd_word = cycle_q;
    end

    assign lane = rd_word >> {mem_addr[1:0], 3'b000};

    always_comb begin
        mem_data_out = '0;
        if (!misaligned) begin
            case (mem_op)
                MEM_LB:          mem_data_out = {{24{lane[7]}}, lane[7:0]};
                MEM_LBU, MEM_SB: mem_data_out = {24'b0, lane[7:0]};
                MEM_LH:          mem_data_out = {{16{lane[15]}}, lane[15:0]};
                MEM_LHU, MEM_SH: mem_data_out = {16'b0, lane[15:0]};
                default:         mem_data_out = rd_word;
            endcase
        end
    end

    // Store data is replicated across lanes; byte_en picks the live ones.
    always_comb begin
        byte_en = 4'b1111;
        wdata   = mem_data_in;
        if (is_byte) begin
            byte_en = 4'b0001 << mem_addr[1:0];
            wdata   = {4{mem_data_in[7:0]}};
        end else if (is_half) begin
            byte_en = 4'b0011 << mem_addr[1:0];
            wdata   = {2{mem_data_in[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && store_ok && in_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign fifo_push = store_ok && hit_tx;

    // A dropped push sets overflow even when a STATUS clear arrives together.
    always_comb begin
        overflow_d = overflow_q;
        if (store_ok && hit_status)  overflow_d = 1'b0;
        if (fifo_push && fifo_full)  overflow_d = 1'b1;
        cycle_d = cycle_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            cycle_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (mem_data_in[7:0]),
        .pop_i       (tx_ready),
        .head_data_o (tx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign tx_valid = !fifo_empty;

endmodule
